am_handler_dispatch: RTL and testbench

// Parametrised Active Message handler dispatcher for the GAScore receive path.
// - Takes one AXI-Stream of AM packets (header beat + payload beats).
// - Decodes the destination kernel from the header (minus address_offset) and latches the AM handler ID.
// - Forwards payload beats to one of NUM_KERNELS AXI-Stream handler channels through a registered output stage.
// - Drops and counts packets whose destination is out of range.
//

---
 rtl/am_handler_dispatch.sv | 147 ++++++++++++++
 tb/tb_am_handler_dispatch.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_handler_dispatch.sv
// Active Message handler dispatcher: decodes the destination kernel from each AM header beat
// and steers the payload beats to one of NUM_KERNELS AXI-Stream channels through one output register.
module am_handler_dispatch #(
   parameter int unsigned NUM_KERNELS = 4,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned DEST_LSB    = 24,
   parameter int unsigned HANDLER_LSB = 52,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [15:0]                      address_offset,
   input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic                             s_axis_tlast,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   output logic [DATA_WIDTH-1:0]            m_axis_tdata,
   output logic                             m_axis_tlast,
   output logic [3:0]                       m_axis_handler,
   output logic [NUM_KERNELS-1:0]           m_axis_tvalid,
   input  logic [NUM_KERNELS-1:0]           m_axis_tready,
   output logic [CNT_WIDTH-1:0]             drop_count,
   output logic [NUM_KERNELS*CNT_WIDTH-1:0] pkt_count,
   output logic                             busy
);

   localparam int unsigned SEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

   typedef enum logic [1:0] {
      ST_HEADER,
      ST_FORWARD,
      ST_DROP
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    in_ready;
   logic                    accept;
   logic                    hdr_accept;
   logic                    load;
   logic                    drain;
   logic [15:0]             dest;
   logic                    dest_ok;
   logic [SEL_W-1:0]        sel;
   logic [3:0]              handler;
   logic                    out_valid;
   logic [SEL_W-1:0]        out_sel;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_last;
   logic [3:0]              out_handler;
   logic [CNT_WIDTH-1:0]    drop_cnt;
   logic [CNT_WIDTH-1:0]    pkt_cnt [NUM_KERNELS];

   // Modulo-2^16 subtraction: destinations below the offset wrap to large values and are rejected.
   assign dest       = s_axis_tdata[DEST_LSB +: 16] - address_offset;
   assign dest_ok    = (32'(dest) < 32'(NUM_KERNELS));
   assign drain      = out_valid & m_axis_tready[out_sel];
   assign accept     = s_axis_tvalid & in_ready;
   assign hdr_accept = accept & (state == ST_HEADER);
   assign load       = accept & (state == ST_FORWARD);

   always_comb begin
      state_next = state;
      in_ready   = 1'b1;
      case (state)
         ST_HEADER: begin
            if (s_axis_tvalid && !s_axis_tlast) begin
               state_next = dest_ok ? ST_FORWARD : ST_DROP;
            end
         end
         ST_FORWARD: begin
            in_ready = ~out_valid | m_axis_tready[out_sel];
            if (accept && s_axis_tlast) begin
               state_next = ST_HEADER;
            end
         end
         ST_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_next = ST_HEADER;
            end
         end
         default: state_next = ST_HEADER;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= ST_HEADER;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sel         <= '0;
         handler     <= '0;
         out_valid   <= 1'b0;
         out_sel     <= '0;
         out_data    <= '0;
         out_last    <= 1'b0;
         out_handler <= '0;
         drop_cnt    <= '0;
         for (int unsigned i = 0; i < NUM_KERNELS; i++) begin
            pkt_cnt[i] <= '0;
         end
      end else begin
         if (hdr_accept && dest_ok && !s_axis_tlast) begin
            sel     <= dest[SEL_W-1:0];
            handler <= s_axis_tdata[HANDLER_LSB +: 4];
         end
         if (hdr_accept && !dest_ok && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_WIDTH'(1);
         end
         // Select and handler ride along with each beat, so the next header may be decoded early.
         if (load) begin
            out_valid   <= 1'b1;
            out_sel     <= sel;
            out_data    <= s_axis_tdata;
            out_last    <= s_axis_tlast;
            out_handler <= handler;
            if (s_axis_tlast && (pkt_cnt[sel] != '1)) begin
               pkt_cnt[sel] <= pkt_cnt[sel] + CNT_WIDTH'(1);
            end
         end else if (drain) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      m_axis_tvalid = '0;
      pkt_count     = '0;
      for (int unsigned i = 0; i < NUM_KERNELS; i++) begin
         m_axis_tvalid[i]                      = out_valid & (out_sel == SEL_W'(i));
         pkt_count[i*CNT_WIDTH +: CNT_WIDTH]   = pkt_cnt[i];
      end
   end

   assign s_axis_tready  = in_ready;
   assign m_axis_tdata   = out_data;
   assign m_axis_tlast   = out_last;
   assign m_axis_handler = out_handler;
   assign drop_count     = drop_cnt;
   assign busy           = (state != ST_HEADER) | out_valid;

endmodule

// File: tb/tb_am_handler_dispatch.sv
// Self-checking bench for am_handler_dispatch: packet-level reference model with an expected-beat
// queue, directed scenarios with literal expectations, then randomized traffic and back-pressure.
module tb_am_handler_dispatch;

   localparam int unsigned NK = 4;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [3:0]  handler;
      int unsigned chan;
   } beat_t;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  tv;
      logic        last;
      logic [3:0]  handler;
   } pop_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] address_offset = 16'h0010;
   logic [63:0] s_axis_tdata = '0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [63:0] m_axis_tdata;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_handler;
   logic [3:0]  m_axis_tvalid;
   logic [3:0]  m_axis_tready = '1;
   logic [15:0] drop_count;
   logic [63:0] pkt_count;
   logic        busy;

   am_handler_dispatch #(
      .NUM_KERNELS (NK),
      .DATA_WIDTH  (64),
      .DEST_LSB    (24),
      .HANDLER_LSB (52),
      .CNT_WIDTH   (16)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .address_offset (address_offset),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tlast   (s_axis_tlast),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tlast   (m_axis_tlast),
      .m_axis_handler (m_axis_handler),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .drop_count     (drop_count),
      .pkt_count      (pkt_count),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   int unsigned pass_n = 0;
   int unsigned total_n = 0;
   int unsigned cyc = 0;
   int unsigned ready_mode = 0;
   logic        gap_en = 1'b0;
   logic        tog = 1'b0;

   beat_t       exp_q[$];
   pop_t        pop_log[$];
   int unsigned acc_log[$];
   int unsigned m_drop = 0;
   int unsigned m_pkt[NK];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [15:0] pc(input int unsigned i);
      return pkt_count[i*16 +: 16];
   endfunction

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Channel ready: 0 all high, 1 random, 2 channel 1 toggling, 3 all low
   initial forever begin
      @(posedge clock);
      #1;
      tog = ~tog;
      case (ready_mode)
         0: m_axis_tready = 4'hF;
         1: m_axis_tready = 4'($urandom_range(0, 15));
         2: m_axis_tready = {2'b11, tog, 1'b1};
         default: m_axis_tready = 4'h0;
      endcase
   end

   // Output compare: every visible beat must equal the head of the expected queue
   initial forever begin
      @(negedge clock);
      if (reset_n) begin
         if (m_axis_tvalid != 4'h0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(m_axis_tvalid), 64'h0);
            end else begin
               chk("out_tvalid", 64'(m_axis_tvalid), 64'(4'b0001 << exp_q[0].chan));
               chk("out_tdata", m_axis_tdata, exp_q[0].data);
               chk("out_tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
               chk("out_handler", 64'(m_axis_handler), 64'(exp_q[0].handler));
               if (m_axis_tready[exp_q[0].chan]) begin
                  pop_log.push_back('{cyc, m_axis_tvalid, m_axis_tlast, m_axis_handler});
                  void'(exp_q.pop_front());
               end
            end
            chk("busy_when_full", 64'(busy), 64'h1);
         end
         if (!s_axis_tready) begin
            chk("tready_low_only_on_stall", 64'(|(m_axis_tvalid & ~m_axis_tready)), 64'h1);
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      pop_log.delete();
      acc_log.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      s_axis_tvalid = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      m_drop = 0;
      for (int i = 0; i < NK; i++) m_pkt[i] = 0;
      clear_logs();
   endtask

   task automatic send_beat(input logic [63:0] d, input logic l);
      logic        took;
      int unsigned tries;
      took = 1'b0;
      tries = 0;
      if (gap_en) begin
         s_axis_tvalid = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
      end
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!took && tries < 1000) begin
         @(negedge clock);
         took = s_axis_tready;
         @(posedge clock);
         #1;
         tries++;
      end
      s_axis_tvalid = 1'b0;
      acc_log.push_back(cyc);
      if (!took) chk("accept_timeout", 64'(took), 64'h1);
   endtask

   // Model works per packet: rebased destination in range -> payload beats expected on that channel
   task automatic send_pkt(input logic [15:0] dst, input logic [3:0] hnd, input int unsigned npay);
      logic [63:0] hdr;
      logic [63:0] pl[$];
      logic [15:0] rel;
      hdr = {$urandom, $urandom};
      hdr[39:24] = dst;
      hdr[55:52] = hnd;
      for (int unsigned k = 0; k < npay; k++) pl.push_back({$urandom, $urandom});
      rel = dst - address_offset;
      if (rel < 16'(NK)) begin
         if (npay > 0) begin
            for (int unsigned k = 0; k < npay; k++) exp_q.push_back('{pl[k], k == npay - 1, hnd, int'(rel)});
            m_pkt[rel]++;
         end
      end else begin
         m_drop++;
      end
      send_beat(hdr, npay == 0);
      for (int unsigned k = 0; k < npay; k++) send_beat(pl[k], k == npay - 1);
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      ready_mode = 0;
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge clock);
         if (!busy && exp_q.size() == 0) done = 1'b1;
      end
      chk("idle_within_bound", 64'(done), 64'h1);
      @(posedge clock);
      #1;
   endtask

   task automatic cmp_counters(input string tag);
      chk({tag, "_drop_count"}, 64'(drop_count), 64'(m_drop));
      for (int i = 0; i < NK; i++) chk({tag, "_pkt_count"}, 64'(pc(i)), 64'(m_pkt[i]));
   endtask

   initial begin
      for (int i = 0; i < NK; i++) m_pkt[i] = 0;
      repeat (2) @(posedge clock);
      #1;
      do_reset();
      @(negedge clock);
      chk("reset_tvalid", 64'(m_axis_tvalid), 64'h0);
      chk("reset_tdata", m_axis_tdata, 64'h0);
      chk("reset_tlast_handler", 64'({m_axis_tlast, m_axis_handler}), 64'h0);
      chk("reset_counters", 64'(drop_count) | pkt_count, 64'h0);
      chk("reset_busy", 64'(busy), 64'h0);
      @(posedge clock);
      #1;

      // Basic delivery to channel 2 with handler 3
      address_offset = 16'h0010;
      clear_logs();
      send_pkt(16'h0012, 4'h3, 3);
      wait_idle();
      chk("basic_beats", 64'(pop_log.size()), 64'd3);
      if (pop_log.size() == 3 && acc_log.size() == 4) begin
         for (int k = 0; k < 3; k++) begin
            chk("basic_tvalid", 64'(pop_log[k].tv), 64'h4);
            chk("basic_handler", 64'(pop_log[k].handler), 64'h3);
            chk("basic_tlast", 64'(pop_log[k].last), 64'(k == 2));
            chk("basic_latency", 64'(pop_log[k].cyc), 64'(acc_log[k+1]));
         end
      end
      chk("basic_pkt2", 64'(pc(2)), 64'd1);

      // Back-pressure on channel 1
      clear_logs();
      ready_mode = 2;
      send_pkt(16'h0011, 4'h5, 8);
      wait_idle();
      chk("bp_beats", 64'(pop_log.size()), 64'd8);
      chk("bp_pkt1", 64'(pc(1)), 64'd1);
      cmp_counters("bp");

      // Out-of-range destinations, then a normal packet
      clear_logs();
      send_pkt(16'h0014, 4'h1, 3);
      send_pkt(16'h000F, 4'h2, 1);
      wait_idle();
      chk("oor_no_output", 64'(pop_log.size()), 64'd0);
      chk("oor_drop", 64'(drop_count), 64'd2);
      send_pkt(16'h0013, 4'h7, 2);
      wait_idle();
      chk("oor_after_pkt3", 64'(pc(3)), 64'd1);

      // Back-to-back packets ch0 then ch3
      clear_logs();
      send_pkt(16'h0010, 4'h4, 2);
      send_pkt(16'h0013, 4'h9, 1);
      wait_idle();
      if (acc_log.size() == 5 && pop_log.size() == 3) begin
         chk("b2b_hdr_next_cycle", 64'(acc_log[3]), 64'(acc_log[2] + 1));
         chk("b2b_chans", {pop_log[0].tv, pop_log[1].tv, pop_log[2].tv}, 64'h118);
         chk("b2b_handlers", {pop_log[0].handler, pop_log[1].handler, pop_log[2].handler}, 64'h449);
         chk("b2b_ch3_latency", 64'(pop_log[2].cyc), 64'(acc_log[4]));
      end else begin
         chk("b2b_counts", 64'({acc_log.size(), pop_log.size()}), {32'd5, 32'd3});
      end

      // Header-only packet
      clear_logs();
      send_pkt(16'h0011, 4'h6, 0);
      @(negedge clock);
      chk("hdr_only_idle", 64'(busy), 64'h0);
      @(posedge clock);
      #1;
      wait_idle();
      chk("hdr_only_no_output", 64'(pop_log.size()), 64'd0);
      chk("hdr_only_pkt1", 64'(pc(1)), 64'd1);
      cmp_counters("hdr_only");

      // Reset while a payload beat sits stalled in the output register
      ready_mode = 3;
      @(posedge clock);
      #1;
      begin
         logic [63:0] hdr;
         logic [63:0] pl;
         hdr = '0;
         hdr[39:24] = 16'h0012;
         hdr[55:52] = 4'h5;
         pl = 64'hDEAD_BEEF_0BAD_F00D;
         exp_q.push_back('{pl, 1'b0, 4'h5, 2});
         send_beat(hdr, 1'b0);
         send_beat(pl, 1'b0);
      end
      @(negedge clock);
      chk("midrst_pre_busy", 64'(busy), 64'h1);
      chk("midrst_pre_tvalid", 64'(m_axis_tvalid), 64'h4);
      @(posedge clock);
      #1;
      do_reset();
      ready_mode = 0;
      @(negedge clock);
      chk("midrst_tvalid", 64'(m_axis_tvalid), 64'h0);
      chk("midrst_counters", 64'(drop_count) | pkt_count, 64'h0);
      chk("midrst_busy", 64'(busy), 64'h0);
      @(posedge clock);
      #1;
      clear_logs();
      send_pkt(16'h0011, 4'h2, 2);
      wait_idle();
      chk("midrst_next_hdr", 64'(pc(1)), 64'd1);
      chk("midrst_next_beats", 64'(pop_log.size()), 64'd2);

      // Randomized traffic around a wrapping offset, then a plain offset
      address_offset = 16'hFFFE;
      ready_mode = 1;
      gap_en = 1'b1;
      for (int n = 0; n < 60; n++) begin
         ready_mode = 1;
         send_pkt(address_offset + 16'($urandom_range(0, 7)) - 16'd2, 4'($urandom), $urandom_range(0, 5));
      end
      wait_idle();
      cmp_counters("rand_wrap");
      address_offset = 16'h0010;
      for (int n = 0; n < 40; n++) begin
         ready_mode = 1;
         send_pkt(address_offset + 16'($urandom_range(0, 7)) - 16'd2, 4'($urandom), $urandom_range(0, 5));
      end
      wait_idle();
      cmp_counters("rand_plain");

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
